count_step_monitor: RTL and testbench
=====================================

Name: count_step_monitor

Overview:
- Sits directly downstream of the 3-bit up/down counter and samples its count output and direction input every enabled cycle.
- Checks that every count transition is a legal ±1 step for the direction in force.
- Reports up-wraps (7->0) and down-wraps (0->7) as pulses and keeps saturating wrap tallies.
- Flags illegal steps with a sticky error, a saturating error count and a capture of the offending transition, for system-level sanity checking.

Parameters:
- WRAP_W, 8, width of each saturating wrap tally.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- en  input  1  sample qualifier; the cycle is ignored when low.
- q_in  input  3  count value from the counter.
- mode  input  1  direction applied to the counter: 0 = up, 1 = down.
- wrap_up  output  1  one-cycle pulse: legal 7->0 step while counting up.
- wrap_dn  output  1  one-cycle pulse: legal 0->7 step while counting down.
- dir_chg  output  1  one-cycle pulse: mode differs from the previous sample.
- up_wraps  output  WRAP_W  saturating count of wrap_up events.
- dn_wraps  output  WRAP_W  saturating count of wrap_dn events.
- step_err  output  1  sticky illegal-step flag.
- err_cnt  output  ERR_W  saturating count of illegal steps.
- err_prev  output  3  previous count of the first illegal step.
- err_cur  output  3  observed count of the first illegal step.

Behaviour:
- Reset:
  - When clr is high at a rising edge, all outputs go to 0, primed goes to 0, and prev_q and prev_mode go to 0.
  - clr overrides en and all other activity, including in the middle of a sequence.
- Internal state:
  - prev_q[2:0], prev_mode, primed.
- Idle cycle (en = 0):
  - All state and tallies hold.
  - wrap_up, wrap_dn and dir_chg are 0 in the following cycle.
- First enabled sample after reset (primed = 0):
  - Capture q_in into prev_q and mode into prev_mode, and set primed.
  - No checks run and no pulses are generated.
- Each later enabled sample (primed = 1):
  - Expected value: if prev_mode = 0, exp = prev_q + 1 mod 8; if prev_mode = 1, exp = prev_q - 1 mod 8.
  - prev_mode is used because the counter's transition is governed by the direction that was in force before the edge.
  - Legal step (q_in == exp):
    - prev_mode = 0, prev_q = 7, q_in = 0: assert wrap_up, and increment up_wraps unless it is all-ones.
    - prev_mode = 1, prev_q = 0, q_in = 7: assert wrap_dn, and increment dn_wraps unless it is all-ones.
  - Illegal step (q_in != exp), including a held value (q_in == prev_q):
    - Set step_err.
    - Increment err_cnt unless it is all-ones.
    - If step_err was 0 before this step, load err_prev = prev_q and err_cur = q_in. Later errors do not overwrite them.
    - No wrap pulse and no wrap tally change on an illegal step, even if the values happen to be 7/0.
  - Direction change: if mode != prev_mode, pulse dir_chg. This is independent of the step check.
  - Resynchronisation: prev_q <= q_in and prev_mode <= mode on every enabled sample, legal or not. Checking resumes against the observed value.
- Latency:
  - All outputs are registered.
  - Pulses and tally updates are visible one cycle after the enabled sample edge.
  - Pulses last exactly one cycle. Back-to-back enabled samples can produce pulses on consecutive cycles.
- Clearing:
  - Only clr clears step_err, err_cnt, err_prev and err_cur. The tallies never roll over.
- Simultaneous events:
  - A wrap together with a dir_chg asserts both pulses.
  - Because the check uses prev_mode, a legal step can coincide with a mode change.

Test Plan:
1. Up wrap: clr, then en = 1, mode = 0, q_in 5,6,7,0,1 -> one wrap_up pulse the cycle after q_in = 0 is sampled; up_wraps = 1; step_err = 0; dir_chg never asserted.
2. Down wrap plus reversal: mode = 0 with q 2,3; then mode = 1 while q 4,3,2,1,0,7 -> dir_chg pulses once (at the sample q = 4); all steps legal; wrap_dn pulses once after 7 is sampled; dn_wraps = 1.
3. Illegal step: mode = 0, q 1,2,5,6 -> step_err = 1, err_cnt = 1, err_prev = 2, err_cur = 5; the 5->6 step is legal (no further increment). Then a stuck value 6,6 -> err_cnt = 2, err_prev/err_cur unchanged.
4. Saturation: ERR_W = 4, drive 20 illegal steps -> err_cnt holds at 15. WRAP_W = 2, drive 5 up-wraps -> up_wraps = 3.
5. en gating: the sequence 3,(en = 0 with garbage 6),4 -> no error (a 3->4 step is checked); no pulses while en is low.
6. Reset mid-run: after errors and wraps, assert clr for one cycle together with en = 1 and a wrap-producing q_in -> all outputs 0 and no pulse. The next sample only primes: q_in = 4 followed by 5 produces no error.

Source files
------------

// File: rtl/count_step_monitor.sv
// rtl/count_step_monitor.sv - step-legality, wrap and error monitor for a 3-bit up/down counter
// Registered pulses and saturating tallies; the expected step uses the direction in force before the edge.
module count_step_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [2:0]        q_in,
  input  logic              mode,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              dir_chg,
  output logic [WRAP_W-1:0] up_wraps,
  output logic [WRAP_W-1:0] dn_wraps,
  output logic              step_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [2:0]        err_prev,
  output logic [2:0]        err_cur
);

  logic [2:0]        r_prev_q;
  logic              r_prev_mode;
  logic              r_primed;
  logic              r_wrap_up;
  logic              r_wrap_dn;
  logic              r_dir_chg;
  logic [WRAP_W-1:0] r_up_wraps;
  logic [WRAP_W-1:0] r_dn_wraps;
  logic              r_step_err;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [2:0]        r_err_prev;
  logic [2:0]        r_err_cur;

  logic [2:0] w_exp;
  logic       w_check;
  logic       w_legal;
  logic       w_wrap_up;
  logic       w_wrap_dn;
  logic       w_err;

  assign w_exp     = r_prev_mode ? (r_prev_q - 3'd1) : (r_prev_q + 3'd1);
  assign w_check   = en & r_primed;
  assign w_legal   = (q_in == w_exp);
  // A legal step out of 7 going up can only land on 0 (and 0 going down on 7).
  assign w_wrap_up = w_check & w_legal & ~r_prev_mode & (r_prev_q == 3'd7);
  assign w_wrap_dn = w_check & w_legal &  r_prev_mode & (r_prev_q == 3'd0);
  assign w_err     = w_check & ~w_legal;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_prev_q    <= '0;
      r_prev_mode <= 1'b0;
      r_primed    <= 1'b0;
      r_wrap_up   <= 1'b0;
      r_wrap_dn   <= 1'b0;
      r_dir_chg   <= 1'b0;
      r_up_wraps  <= '0;
      r_dn_wraps  <= '0;
      r_step_err  <= 1'b0;
      r_err_cnt   <= '0;
      r_err_prev  <= '0;
      r_err_cur   <= '0;
    end else begin
      r_wrap_up <= w_wrap_up;
      r_wrap_dn <= w_wrap_dn;
      r_dir_chg <= w_check & (mode != r_prev_mode);
      if (en) begin
        r_prev_q    <= q_in;
        r_prev_mode <= mode;
        r_primed    <= 1'b1;
      end
      if (w_wrap_up && !(&r_up_wraps)) r_up_wraps <= r_up_wraps + WRAP_W'(1);
      if (w_wrap_dn && !(&r_dn_wraps)) r_dn_wraps <= r_dn_wraps + WRAP_W'(1);
      if (w_err) begin
        r_step_err <= 1'b1;
        if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_W'(1);
        // Only the first offending transition is kept for post-mortem.
        if (!r_step_err) begin
          r_err_prev <= r_prev_q;
          r_err_cur  <= q_in;
        end
      end
    end
  end

  assign wrap_up  = r_wrap_up;
  assign wrap_dn  = r_wrap_dn;
  assign dir_chg  = r_dir_chg;
  assign up_wraps = r_up_wraps;
  assign dn_wraps = r_dn_wraps;
  assign step_err = r_step_err;
  assign err_cnt  = r_err_cnt;
  assign err_prev = r_err_prev;
  assign err_cur  = r_err_cur;

endmodule

// File: tb/tb_count_step_monitor.sv
// tb/tb_count_step_monitor.sv - directed and randomized check of count_step_monitor
// A sample-level model predicts every output; directed steps pin known literal results.
module tb_count_step_monitor;
  localparam int WRAP_W = 2;
  localparam int ERR_W  = 4;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr, en, mode;
  logic [2:0]        q_in;
  logic              wrap_up, wrap_dn, dir_chg, step_err;
  logic [WRAP_W-1:0] up_wraps, dn_wraps;
  logic [ERR_W-1:0]  err_cnt;
  logic [2:0]        err_prev, err_cur;

  count_step_monitor #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in), .mode(mode),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .dir_chg(dir_chg),
    .up_wraps(up_wraps), .dn_wraps(dn_wraps),
    .step_err(step_err), .err_cnt(err_cnt),
    .err_prev(err_prev), .err_cur(err_cur)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp[31:0]) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one update per sample, written in terms of the rules.
  bit m_valid = 0;
  int m_primed, m_pq, m_pm;
  int e_wu, e_wd, e_dc, e_up, e_dn, e_se, e_ec, e_ep, e_ecur;

  always @(posedge clk) begin
    int expq;
    e_wu = 0; e_wd = 0; e_dc = 0;
    if (clr) begin
      m_valid = 1;
      m_primed = 0; m_pq = 0; m_pm = 0;
      e_up = 0; e_dn = 0; e_se = 0; e_ec = 0; e_ep = 0; e_ecur = 0;
    end else if (en) begin
      if (m_primed == 1) begin
        expq = (m_pm == 0) ? (m_pq + 1) % 8 : (m_pq + 7) % 8;
        if (int'(q_in) == expq) begin
          if (m_pm == 0 && m_pq == 7) begin
            e_wu = 1;
            if (e_up < WRAP_MAX) e_up++;
          end
          if (m_pm == 1 && m_pq == 0) begin
            e_wd = 1;
            if (e_dn < WRAP_MAX) e_dn++;
          end
        end else begin
          if (e_se == 0) begin
            e_ep = m_pq;
            e_ecur = int'(q_in);
          end
          e_se = 1;
          if (e_ec < ERR_MAX) e_ec++;
        end
        e_dc = (int'(mode) != m_pm) ? 1 : 0;
      end
      m_primed = 1;
      m_pq = int'(q_in);
      m_pm = int'(mode);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("wrap_up",  wrap_up,  e_wu);
      chk("wrap_dn",  wrap_dn,  e_wd);
      chk("dir_chg",  dir_chg,  e_dc);
      chk("up_wraps", up_wraps, e_up);
      chk("dn_wraps", dn_wraps, e_dn);
      chk("step_err", step_err, e_se);
      chk("err_cnt",  err_cnt,  e_ec);
      chk("err_prev", err_prev, e_ep);
      chk("err_cur",  err_cur,  e_ecur);
    end
  end

  task automatic drv(input logic c, input logic e, input int q, input logic m);
    clr = c; en = e; q_in = q[2:0]; mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wrap_up"},  wrap_up,  0);
    chk({tag, "_wrap_dn"},  wrap_dn,  0);
    chk({tag, "_dir_chg"},  dir_chg,  0);
    chk({tag, "_up_wraps"}, up_wraps, 0);
    chk({tag, "_dn_wraps"}, dn_wraps, 0);
    chk({tag, "_step_err"}, step_err, 0);
    chk({tag, "_err_cnt"},  err_cnt,  0);
    chk({tag, "_err_prev"}, err_prev, 0);
    chk({tag, "_err_cur"},  err_cur,  0);
  endtask

  initial begin
    int up_seq[5];
    int dn_seq[6];
    int gq, gm, nq, nm;
    up_seq = '{5, 6, 7, 0, 1};
    dn_seq = '{4, 3, 2, 1, 0, 7};
    clr = 1'b1; en = 1'b0; q_in = 3'd0; mode = 1'b0;
    drv(1, 0, 0, 0);
    drv(1, 0, 0, 0);
    chk_all_zero("reset");

    // Up wrap
    foreach (up_seq[i]) begin
      drv(0, 1, up_seq[i], 0);
      chk("t1_wrap_up", wrap_up, (up_seq[i] == 0) ? 1 : 0);
      chk("t1_dir_chg", dir_chg, 0);
    end
    chk("t1_up_wraps", up_wraps, 1);
    chk("t1_step_err", step_err, 0);

    // Down wrap plus reversal
    drv(0, 1, 2, 0);
    drv(0, 1, 3, 0);
    foreach (dn_seq[i]) begin
      drv(0, 1, dn_seq[i], 1);
      chk("t2_dir_chg", dir_chg, (i == 0) ? 1 : 0);
      chk("t2_wrap_dn", wrap_dn, (dn_seq[i] == 7) ? 1 : 0);
    end
    chk("t2_dn_wraps", dn_wraps, 1);
    chk("t2_step_err", step_err, 0);

    // Illegal step, then a held value
    drv(1, 0, 0, 0);
    drv(0, 1, 1, 0);
    drv(0, 1, 2, 0);
    drv(0, 1, 5, 0);
    chk("t3_step_err", step_err, 1);
    chk("t3_err_cnt",  err_cnt,  1);
    chk("t3_err_prev", err_prev, 2);
    chk("t3_err_cur",  err_cur,  5);
    drv(0, 1, 6, 0);
    chk("t3_err_cnt_legal", err_cnt, 1);
    drv(0, 1, 6, 0);
    chk("t3_err_cnt_stuck", err_cnt, 2);
    chk("t3_err_prev_kept", err_prev, 2);
    chk("t3_err_cur_kept",  err_cur,  5);

    // Saturation
    for (int i = 0; i < 20; i++) drv(0, 1, 6, 0);
    chk("t4_err_cnt_sat", err_cnt, 15);
    for (int i = 0; i < 40; i++) drv(0, 1, (7 + i) % 8, 0);
    chk("t4_up_wraps_sat", up_wraps, 3);

    // en gating
    drv(1, 0, 0, 0);
    drv(0, 1, 3, 0);
    drv(0, 0, 6, 1);
    chk("t5_wrap_up_idle", wrap_up, 0);
    chk("t5_dir_chg_idle", dir_chg, 0);
    drv(0, 1, 4, 0);
    chk("t5_step_err", step_err, 0);

    // Reset mid-run
    drv(0, 1, 6, 0);
    drv(0, 1, 7, 0);
    chk("t6_pre_step_err", step_err, 1);
    drv(1, 1, 0, 0);
    chk_all_zero("t6_clr");
    drv(0, 1, 4, 0);
    chk("t6_prime_err", step_err, 0);
    drv(0, 1, 5, 0);
    chk("t6_step_err", step_err, 0);
    chk("t6_err_cnt",  err_cnt,  0);

    // Randomized run: mostly legal counter behaviour with injected faults
    gq = 5; gm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        drv(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
        gq = 0; gm = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        drv(0, 0, $urandom_range(0, 7), $urandom_range(0, 1));
      end else begin
        if ($urandom_range(0, 99) < 88) nq = (gm == 0) ? (gq + 1) % 8 : (gq + 7) % 8;
        else nq = $urandom_range(0, 7);
        nm = ($urandom_range(0, 9) == 0) ? 1 - gm : gm;
        drv(0, 1, nq, nm[0]);
        gq = nq; gm = nm;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
